// File: rtl/systolic_tile_scheduler.sv
// rtl/systolic_tile_scheduler.sv - GEMM tile sequencer driving the systolic array controller
//
// Walks one job as a grid of N_SIZE x N_SIZE weight tiles, n-outer / k-inner.
// For every tile it streams N_SIZE weight rows into the array, leaves a one-cycle
// gap, waits for the controller to report ready, then holds valid_in until the
// controller signals the activation pass is complete.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             job request, only honoured while idle
//   cfg_k_tiles       reduction tiles per column tile (latched on start)
//   cfg_n_tiles       column tiles (latched on start)
//   sa_ready/sa_done  controller idle indication / pass-complete pulse
//   sa_load_weight    controller load_weight
//   sa_valid_in       controller valid_in
//   wt_rd_en/addr     weight-buffer read port
//   acc_clear         accumulator overwrite flag for k==0 passes
//   tile_k_idx/n_idx  current tile coordinates
//   busy/done         job in progress / one-cycle end-of-job pulse
module systolic_tile_scheduler #(
  parameter int N_SIZE     = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TILE_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TILE_W-1:0]     cfg_k_tiles,
  input  logic [TILE_W-1:0]     cfg_n_tiles,
  input  logic                  sa_ready,
  input  logic                  sa_done,
  output logic                  sa_load_weight,
  output logic                  sa_valid_in,
  output logic                  wt_rd_en,
  output logic [ADDR_WIDTH-1:0] wt_rd_addr,
  output logic                  acc_clear,
  output logic [TILE_W-1:0]     tile_k_idx,
  output logic [TILE_W-1:0]     tile_n_idx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WT,
    GAP,
    WAIT_RDY,
    COMPUTE,
    ADVANCE,
    FINISH
  } state_t;

  localparam int ROW_W = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
  localparam logic [ROW_W-1:0]      LAST_ROW    = ROW_W'(N_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] TILE_STRIDE = ADDR_WIDTH'(N_SIZE);
  localparam logic [TILE_W-1:0]     ONE_TILE    = TILE_W'(1);

  state_t                  state;
  logic [ROW_W-1:0]        row;
  logic [ADDR_WIDTH-1:0]   base;
  logic [TILE_W-1:0]       k_tiles;
  logic [TILE_W-1:0]       n_tiles;

  // Every output is a register, so each transition also sets the outputs the
  // destination state presents in its first cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      row            <= '0;
      base           <= '0;
      k_tiles        <= '0;
      n_tiles        <= '0;
      sa_load_weight <= 1'b0;
      sa_valid_in    <= 1'b0;
      wt_rd_en       <= 1'b0;
      wt_rd_addr     <= '0;
      acc_clear      <= 1'b0;
      tile_k_idx     <= '0;
      tile_n_idx     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_tiles    <= cfg_k_tiles;
            n_tiles    <= cfg_n_tiles;
            tile_k_idx <= '0;
            tile_n_idx <= '0;
            base       <= '0;
            row        <= '0;
            busy       <= 1'b1;
            // An empty grid still reports completion so the layer sequencer
            // never stalls on a degenerate job.
            if (cfg_k_tiles == '0 || cfg_n_tiles == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state          <= LOAD_WT;
              sa_load_weight <= 1'b1;
              wt_rd_en       <= 1'b1;
              wt_rd_addr     <= '0;
            end
          end
        end

        LOAD_WT: begin
          if (row == LAST_ROW) begin
            state          <= GAP;
            sa_load_weight <= 1'b0;
            wt_rd_en       <= 1'b0;
            row            <= '0;
          end else begin
            row        <= row + 1'b1;
            wt_rd_addr <= wt_rd_addr + 1'b1;
          end
        end

        GAP: begin
          state     <= WAIT_RDY;
          acc_clear <= (tile_k_idx == '0);
        end

        // sa_done is deliberately not looked at here; only sa_ready matters.
        WAIT_RDY: begin
          if (sa_ready) begin
            state       <= COMPUTE;
            sa_valid_in <= 1'b1;
          end
        end

        COMPUTE: begin
          if (sa_done) begin
            state       <= ADVANCE;
            sa_valid_in <= 1'b0;
            acc_clear   <= 1'b0;
          end
        end

        // Base advances by one tile stride each pass, so tile t lands on
        // t*N_SIZE without a multiplier; wrapping past the buffer is allowed.
        ADVANCE: begin
          base       <= base + TILE_STRIDE;
          wt_rd_addr <= base + TILE_STRIDE;
          if (tile_k_idx != k_tiles - ONE_TILE) begin
            tile_k_idx     <= tile_k_idx + ONE_TILE;
            state          <= LOAD_WT;
            sa_load_weight <= 1'b1;
            wt_rd_en       <= 1'b1;
          end else begin
            tile_k_idx <= '0;
            if (tile_n_idx != n_tiles - ONE_TILE) begin
              tile_n_idx     <= tile_n_idx + ONE_TILE;
              state          <= LOAD_WT;
              sa_load_weight <= 1'b1;
              wt_rd_en       <= 1'b1;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end

        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// tb/tb_systolic_tile_scheduler.sv - directed self-checking bench for systolic_tile_scheduler
module tb_systolic_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] cfg_k_tiles;
  logic [5:0] cfg_n_tiles;
  logic       sa_ready;
  logic       sa_done;
  logic       sa_load_weight;
  logic       sa_valid_in;
  logic       wt_rd_en;
  logic [9:0] wt_rd_addr;
  logic       acc_clear;
  logic [5:0] tile_k_idx;
  logic [5:0] tile_n_idx;
  logic       busy;
  logic       done;

  int n_compared   = 0;
  int n_mismatched = 0;

  systolic_tile_scheduler #(.N_SIZE(32), .ADDR_WIDTH(10), .TILE_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_k_tiles    (cfg_k_tiles),
    .cfg_n_tiles    (cfg_n_tiles),
    .sa_ready       (sa_ready),
    .sa_done        (sa_done),
    .sa_load_weight (sa_load_weight),
    .sa_valid_in    (sa_valid_in),
    .wt_rd_en       (wt_rd_en),
    .wt_rd_addr     (wt_rd_addr),
    .acc_clear      (acc_clear),
    .tile_k_idx     (tile_k_idx),
    .tile_n_idx     (tile_n_idx),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] all_outputs();
    return {sa_load_weight, sa_valid_in, wt_rd_en, wt_rd_addr, acc_clear,
            tile_k_idx, tile_n_idx, busy, done};
  endfunction

  // Entered on the first LOAD_WT cycle of tile t; leaves on the cycle after ADVANCE.
  task automatic run_pass(input int t, input int k, input int n, input int ready_dly,
                          input int done_dly, input bit spur, input bit pulse_start);
    int bad;
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      if (!(sa_load_weight && wt_rd_en && !sa_valid_in && busy &&
            wt_rd_addr == 10'((t * 32 + r) % 1024))) bad++;
      sa_done = (spur && r == 3);
      start   = (pulse_start && r == 5);
      tick();
    end
    sa_done = 1'b0;
    start   = 1'b0;
    check($sformatf("load_rows_t%0d", t), bad, 0);
    check("gap_idle", {sa_load_weight, wt_rd_en, sa_valid_in}, 0);
    tick();
    bad = 0;
    for (int i = 0; i < ready_dly; i++) begin
      if (sa_valid_in) bad++;
      tick();
    end
    check("wait_rdy_hold", bad, 0);
    sa_ready = 1'b1;
    sa_done  = spur;
    tick();
    sa_ready = 1'b0;
    sa_done  = 1'b0;
    check("valid_rise", sa_valid_in, 1);
    check($sformatf("acc_clear_t%0d", t), acc_clear, (k == 0));
    check($sformatf("k_idx_t%0d", t), tile_k_idx, k);
    check($sformatf("n_idx_t%0d", t), tile_n_idx, n);
    bad = 0;
    for (int i = 0; i < done_dly; i++) begin
      if (!sa_valid_in) bad++;
      if (i == done_dly - 1) sa_done = 1'b1;
      tick();
    end
    sa_done = 1'b0;
    check("valid_hold", bad, 0);
    check("advance_outs", {sa_valid_in, acc_clear, done, busy}, 4'b0001);
    tick();
  endtask

  task automatic run_job(input int kt, input int nt, input int ready_dly, input bit spur);
    cfg_k_tiles = 6'(kt);
    cfg_n_tiles = 6'(nt);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start", busy, 1);
    for (int n = 0; n < nt; n++)
      for (int k = 0; k < kt; k++)
        run_pass(n * kt + k, k, n, ready_dly, 10, spur, 1'b0);
    check("finish_done", {done, busy, sa_load_weight, sa_valid_in}, 4'b1100);
    tick();
    check("after_done", {done, busy}, 2'b00);
  endtask

  initial begin
    int bad;
    int waited;
    rst_n = 1'b0; start = 1'b0; cfg_k_tiles = '0; cfg_n_tiles = '0;
    sa_ready = 1'b0; sa_done = 1'b0;
    tick(); tick();
    check("reset_outs", all_outputs(), 0);
    rst_n = 1'b1;
    tick();

    // single tile, immediate ready, done 10 cycles after valid_in
    run_job(1, 1, 0, 1'b0);
    // 3 x 2 grid
    run_job(3, 2, 0, 1'b0);

    // empty grids: done pulse without any array activity
    cfg_k_tiles = 6'd0; cfg_n_tiles = 6'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_k_done", {done, busy, sa_load_weight, sa_valid_in, wt_rd_en}, 5'b11000);
    tick();
    check("zero_k_after", {done, busy, sa_load_weight, sa_valid_in}, 4'b0000);
    cfg_k_tiles = 6'd4; cfg_n_tiles = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_n_done", {done, busy, sa_load_weight}, 3'b110);
    tick();

    // slow ready, spurious sa_done in LOAD_WT and alongside sa_ready
    run_job(1, 1, 20, 1'b1);

    // second start mid-job, then reset during tile 2 compute
    cfg_k_tiles = 6'd3; cfg_n_tiles = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    run_pass(0, 0, 0, 0, 10, 1'b0, 1'b1);
    run_pass(1, 1, 0, 0, 10, 1'b0, 1'b0);
    check("tile2_addr", wt_rd_addr, 64);
    sa_ready = 1'b1;
    waited = 0;
    while (!sa_valid_in && waited < 100) begin
      tick();
      waited++;
    end
    sa_ready = 1'b0;
    check("tile2_compute_reached", sa_valid_in, 1);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("mid_reset_outs", all_outputs(), 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      sa_done = 1'b1;
      tick();
      if (done || busy || sa_load_weight) bad++;
    end
    sa_done = 1'b0;
    check("no_done_after_reset", bad, 0);
    run_job(1, 1, 0, 1'b0);

    // 33 reduction tiles: tile 31 at 992, tile 32 wraps to 0
    run_job(33, 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
